// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and stall/freeze controller for the 5-stage MIPS pipeline.
// Bypass selects are combinational; the stall FSM and stall-cycle counter are registered.
module hazard_forward_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic              Clk_i,
    input  logic              Reset_i,
    input  logic [ADDR_W-1:0] IFID_Rs_i,
    input  logic [ADDR_W-1:0] IFID_Rt_i,
    input  logic              IFID_UsesRt_i,
    input  logic [ADDR_W-1:0] IDEX_Reg1_i,
    input  logic [ADDR_W-1:0] IDEX_Reg2_i,
    input  logic [ADDR_W-1:0] IDEX_RegDes_i,
    input  logic              IDEX_MemRead_i,
    input  logic              IDEX_MemWrite_i,
    input  logic              IDEX_jr_i,
    input  logic [ADDR_W-1:0] EXMEM_RegDes_i,
    input  logic              EXMEM_RegWrite_i,
    input  logic              EXMEM_MemRead_i,
    input  logic              EXMEM_MemWrite_i,
    input  logic [ADDR_W-1:0] MEMWB_RegDes_i,
    input  logic              MEMWB_RegWrite_i,
    input  logic              DMem_Ready_i,
    output logic [1:0]        E_MuxAlu_1_o,
    output logic [1:0]        E_MuxAlu_2_o,
    output logic [1:0]        E_jrMux_o,
    output logic              E_MuxWriteData_o,
    output logic              PC_Write_o,
    output logic              IFID_Write_o,
    output logic              IDEX_Bubble_o,
    output logic              Pipe_Freeze_o,
    output logic [CNT_W-1:0]  StallCount_o
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

    localparam logic [2:0]       LU_INIT = 3'(LU_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           stateQ, stateD;
    logic [2:0]       cntQ, cntD;
    logic [CNT_W-1:0] stallCountQ, stallCountD;

    logic             exOk, wbOk, loadUse, memWait;
    logic [ADDR_W-1:0] alu2Src;
    logic [1:0]       alu1Sel, alu2Sel, jrSel;
    logic             writeDataSel;
    logic             pcW, ifW, bub, frz;

    // EXMEM result wins over MEMWB; a load in MEM has no ALU result to bypass yet.
    function automatic logic [1:0] fwdSel(input logic [ADDR_W-1:0] src,
                                          input logic [ADDR_W-1:0] exDes,
                                          input logic [ADDR_W-1:0] wbDes,
                                          input logic exValid,
                                          input logic wbValid);
        if (exValid && src == exDes)
            return 2'd1;
        else if (wbValid && src == wbDes)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    always_comb begin
        exOk         = EXMEM_RegWrite_i & ~EXMEM_MemRead_i & (EXMEM_RegDes_i != '0);
        wbOk         = MEMWB_RegWrite_i & (MEMWB_RegDes_i != '0);
        alu2Src      = IDEX_MemWrite_i ? IDEX_RegDes_i : IDEX_Reg2_i;
        alu1Sel      = fwdSel(IDEX_Reg1_i, EXMEM_RegDes_i, MEMWB_RegDes_i, exOk, wbOk);
        alu2Sel      = fwdSel(alu2Src, EXMEM_RegDes_i, MEMWB_RegDes_i, exOk, wbOk);
        jrSel        = IDEX_jr_i ? alu1Sel : 2'd0;
        writeDataSel = EXMEM_MemWrite_i & wbOk & (EXMEM_RegDes_i == MEMWB_RegDes_i);
        loadUse      = IDEX_MemRead_i & (IDEX_RegDes_i != '0) &
                       ((IDEX_RegDes_i == IFID_Rs_i) |
                        (IFID_UsesRt_i & (IDEX_RegDes_i == IFID_Rt_i)));
        memWait      = (EXMEM_MemRead_i | EXMEM_MemWrite_i) & ~DMem_Ready_i;
    end

    // A memory wait freezes everything and outranks load-use; a freeze inside
    // LU_STALL leaves the remaining bubble count untouched.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        pcW    = 1'b1;
        ifW    = 1'b1;
        bub    = 1'b0;
        frz    = 1'b0;
        case (stateQ)
            RUN: begin
                if (memWait) begin
                    frz    = 1'b1;
                    pcW    = 1'b0;
                    ifW    = 1'b0;
                    stateD = MEM_WAIT;
                end else if (loadUse) begin
                    pcW = 1'b0;
                    ifW = 1'b0;
                    bub = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        cntD   = LU_INIT;
                        stateD = LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                pcW = 1'b0;
                ifW = 1'b0;
                if (memWait) begin
                    frz = 1'b1;
                end else begin
                    bub = 1'b1;
                    if (cntQ == 3'd1) begin
                        cntD   = 3'd0;
                        stateD = RUN;
                    end else begin
                        cntD = cntQ - 3'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (!DMem_Ready_i) begin
                    frz = 1'b1;
                    pcW = 1'b0;
                    ifW = 1'b0;
                end else begin
                    stateD = RUN;
                end
            end
            default: begin
                stateD = RUN;
                cntD   = 3'd0;
            end
        endcase
    end

    always_comb begin
        stallCountD = stallCountQ;
        if (!pcW && stallCountQ != CNT_MAX)
            stallCountD = stallCountQ + CNT_W'(1);
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            stateQ      <= RUN;
            cntQ        <= 3'd0;
            stallCountQ <= '0;
        end else begin
            stateQ      <= stateD;
            cntQ        <= cntD;
            stallCountQ <= stallCountD;
        end
    end

    // Reset forces a plain-run view on every control output.
    always_comb begin
        E_MuxAlu_1_o     = Reset_i ? 2'd0 : alu1Sel;
        E_MuxAlu_2_o     = Reset_i ? 2'd0 : alu2Sel;
        E_jrMux_o        = Reset_i ? 2'd0 : jrSel;
        E_MuxWriteData_o = ~Reset_i & writeDataSel;
        PC_Write_o       = Reset_i | pcW;
        IFID_Write_o     = Reset_i | ifW;
        IDEX_Bubble_o    = ~Reset_i & bub;
        Pipe_Freeze_o    = ~Reset_i & frz;
        StallCount_o     = stallCountQ;
    end

endmodule
